// File: rtl/osnt_sume_tx_ts_queue.sv
// osnt_sume_tx_ts_queue
//   TX egress queue for one OSNT port, between the packet generator and the 10G MAC.
//   Packets are buffered store-and-forward. A configurable beat has its low TS_WIDTH bits
//   overwritten with a timestamp captured when the packet leaves IDLE. The queue enforces a
//   programmable inter-packet gap and keeps packet and byte counters. A packet larger than the
//   data FIFO is forwarded cut-through.
// Ports
//   axis_aclk, axis_resetn  clock, asynchronous active-low reset
//   s_axis_*                ingress AXI-Stream from the generator (tuser ignored)
//   m_axis_*                egress AXI-Stream to the MAC (tuser tied to 0)
//   tx_ts_pos               1-based beat index that receives the timestamp, 0 disables
//   ifg_cycles              extra idle cycles inserted between packets
//   timestamp_156           free-running timestamp
//   clear                   synchronous clear of the counters
//   tx_pkt_count            packets sent
//   tx_byte_count           bytes sent
module osnt_sume_tx_ts_queue #(
    parameter int unsigned C_AXIS_DATA_WIDTH    = 64,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned TS_WIDTH             = 64,
    parameter int unsigned DATA_DEPTH_BITS      = 9,
    parameter int unsigned PKT_DEPTH_BITS       = 5
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   tx_ts_pos,
    input  logic [7:0]                      ifg_cycles,
    input  logic [TS_WIDTH-1:0]             timestamp_156,
    input  logic                            clear,
    output logic [31:0]                     tx_pkt_count,
    output logic [63:0]                     tx_byte_count
);

    localparam int unsigned KEEP_W     = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned DATA_DEPTH = 1 << DATA_DEPTH_BITS;
    localparam int unsigned CNT_W      = $clog2(KEEP_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // tuser carries nothing the egress side needs
    logic tuser_unused;
    assign tuser_unused = ^s_axis_tuser;

    // ---------------------------------------------------------------- data FIFO
    logic [C_AXIS_DATA_WIDTH-1:0] mem_data [DATA_DEPTH];
    logic [KEEP_W-1:0]            mem_keep [DATA_DEPTH];
    logic                         mem_last [DATA_DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [DATA_DEPTH_BITS:0] wr_ptr, rd_ptr;
    logic                     data_empty, data_full;
    logic [PKT_DEPTH_BITS:0]  pkt_cnt;
    logic                     pkt_empty, pkt_full;
    logic                     wr_en, out_hs, pkt_push, pkt_pop;

    assign data_empty = (wr_ptr == rd_ptr);
    assign data_full  = (wr_ptr[DATA_DEPTH_BITS] != rd_ptr[DATA_DEPTH_BITS]) &&
                        (wr_ptr[DATA_DEPTH_BITS-1:0] == rd_ptr[DATA_DEPTH_BITS-1:0]);
    assign pkt_empty  = (pkt_cnt == '0);
    // Counter tops out at exactly 2^PKT_DEPTH_BITS, so the MSB alone flags full
    assign pkt_full   = pkt_cnt[PKT_DEPTH_BITS];

    assign s_axis_tready = axis_resetn & ~data_full & ~pkt_full;
    assign wr_en         = s_axis_tvalid & s_axis_tready;
    assign pkt_push      = wr_en & s_axis_tlast;

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem_data[wr_ptr[DATA_DEPTH_BITS-1:0]] <= s_axis_tdata;
            mem_keep[wr_ptr[DATA_DEPTH_BITS-1:0]] <= s_axis_tkeep;
            mem_last[wr_ptr[DATA_DEPTH_BITS-1:0]] <= s_axis_tlast;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (out_hs) rd_ptr <= rd_ptr + 1'b1;
            case ({pkt_push, pkt_pop})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------- egress FSM
    logic [1:0]                    state, state_next;
    logic [7:0]                    gap_cnt;
    logic [TS_WIDTH-1:0]           ts_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] ts_cnt, ts_pos_q;
    logic                          sending, start, ts_hit;
    logic [C_AXIS_DATA_WIDTH-1:0]  out_data;

    assign sending = (state == ST_HEAD) || (state == ST_SEND);
    // Cut-through: a full FIFO with no complete packet can only hold the head of an oversized one
    assign start   = (state == ST_IDLE) && (!pkt_empty || data_full);

    assign m_axis_tvalid = sending & ~data_empty;
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign pkt_pop       = out_hs & m_axis_tlast;
    assign ts_hit        = (ts_pos_q != '0) && (ts_cnt == ts_pos_q);

    always_comb begin
        out_data = mem_data[rd_ptr[DATA_DEPTH_BITS-1:0]];
        if (ts_hit) out_data[TS_WIDTH-1:0] = ts_reg;
    end

    // Outputs are forced to 0 whenever no beat is presented (including during reset)
    assign m_axis_tdata = m_axis_tvalid ? out_data : '0;
    assign m_axis_tkeep = m_axis_tvalid ? mem_keep[rd_ptr[DATA_DEPTH_BITS-1:0]] : '0;
    assign m_axis_tlast = m_axis_tvalid ? mem_last[rd_ptr[DATA_DEPTH_BITS-1:0]] : 1'b0;
    assign m_axis_tuser = 1'b0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_HEAD;
            ST_HEAD, ST_SEND: begin
                if (out_hs) begin
                    if (m_axis_tlast) state_next = (ifg_cycles != 8'd0) ? ST_GAP : ST_IDLE;
                    else              state_next = ST_SEND;
                end
            end
            ST_GAP:  if (gap_cnt <= 8'd1) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            ts_reg   <= '0;
            ts_cnt   <= C_S_AXI_DATA_WIDTH'(1);
            ts_pos_q <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                ts_reg   <= timestamp_156;
                ts_pos_q <= tx_ts_pos;
                ts_cnt   <= C_S_AXI_DATA_WIDTH'(1);
            end else if (out_hs) begin
                ts_cnt <= ts_cnt + 1'b1;
            end
            // GAP lasts ifg_cycles cycles; the following IDLE cycle supplies the extra one
            if (pkt_pop) begin
                gap_cnt <= ifg_cycles;
            end else if (state == ST_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- counters
    logic [CNT_W-1:0] keep_bytes;

    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_bytes = keep_bytes + CNT_W'(m_axis_tkeep[i]);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            tx_pkt_count  <= '0;
            tx_byte_count <= '0;
        end else if (clear) begin
            tx_pkt_count  <= '0;
            tx_byte_count <= '0;
        end else if (out_hs) begin
            tx_byte_count <= tx_byte_count + 64'(keep_bytes);
            if (m_axis_tlast) tx_pkt_count <= tx_pkt_count + 1'b1;
        end
    end

endmodule
